// File: rtl/md_sched.sv
// Multiply/divide sequencer for the MIPS E stage: owns HI/LO, counts out the
// mult/div latency and requests a F/D freeze plus E bubble for dependent D ops.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_uses_md,
  output logic        E_busy,
  output logic        md_stall,
  output logic        md_done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          done_q, done_d;

  logic          md_start;
  logic          is_mult;
  logic          b_zero;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   div_b, abs_a, abs_b, qu, ru, q_mag, r_mag, qs, rs;
  logic [63:0]   result;

  assign md_start = E_start && (E_md_op >= 3'd1) && (E_md_op <= 3'd4);
  assign is_mult  = (E_md_op == 3'd1) || (E_md_op == 3'd2);
  assign b_zero   = (E_B == '0);

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to
  // 0x80000000 rem 0 without relying on simulator overflow behaviour.
  always_comb begin
    prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u = {32'd0, E_A} * {32'd0, E_B};
    div_b  = b_zero ? 32'd1 : E_B;
    qu     = E_A / div_b;
    ru     = E_A % div_b;
    abs_a  = E_A[31] ? (~E_A + 32'd1) : E_A;
    abs_b  = div_b[31] ? (~div_b + 32'd1) : div_b;
    q_mag  = abs_a / abs_b;
    r_mag  = abs_a % abs_b;
    qs     = (E_A[31] ^ div_b[31]) ? (~q_mag + 32'd1) : q_mag;
    rs     = E_A[31] ? (~r_mag + 32'd1) : r_mag;
    case (E_md_op)
      3'd1:    result = prod_s;
      3'd2:    result = prod_u;
      3'd3:    result = b_zero ? {hi_q, lo_q} : {rs, qs};
      3'd4:    result = b_zero ? {hi_q, lo_q} : {ru, qu};
      default: result = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          phi_d   = result[63:32];
          plo_d   = result[31:0];
          cnt_d   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_d = BUSY;
        end else if (E_start && (E_md_op == 3'd5)) begin
          hi_d = E_A;
        end else if (E_start && (E_md_op == 3'd6)) begin
          lo_d = E_A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      done_q  <= done_d;
    end
  end

  assign E_busy   = (state_q == BUSY);
  assign md_stall = D_uses_md && (md_start || E_busy);
  assign md_done  = done_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: inputs change just after posedge, outputs are
// sampled on the following negedge.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_A, E_B;
  logic        D_uses_md;
  logic        E_busy, md_stall, md_done;
  logic [31:0] HI, LO;

  int checks   = 0;
  int failures = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_start(E_start), .E_md_op(E_md_op),
    .E_A(E_A), .E_B(E_B), .D_uses_md(D_uses_md), .E_busy(E_busy),
    .md_stall(md_stall), .md_done(md_done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a start for one cycle, then idles until the commit cycle (cycle n+1).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    E_start = 1'b1; E_md_op = op; E_A = a; E_B = b;
    step();
    E_start = 1'b0; E_md_op = 3'd0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; E_start = 1'b0; E_md_op = 3'd0; E_A = '0; E_B = '0; D_uses_md = 1'b1;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({E_busy, md_stall, md_done} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {E_busy, md_stall, md_done});
    end
    checks++;
    if ({HI, LO} !== 64'd0) begin
      failures++; $display("FAIL reset_hilo: got %h expected 0", {HI, LO});
    end
    D_uses_md = 1'b0;
    step();
  endtask

  task automatic test_mult();
    E_start = 1'b1; E_md_op = 3'd1; E_A = 32'hFFFF_FFFE; E_B = 32'd3;
    @(negedge clk);
    checks++;
    if (E_busy !== 1'b0) begin
      failures++; $display("FAIL mult_c0_busy: got %b expected 0", E_busy);
    end
    step();
    E_start = 1'b0; E_md_op = 3'd0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (E_busy !== 1'b1 || md_done !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
        failures++;
        $display("FAIL mult_busy_c%0d: got busy=%b done=%b HI=%h LO=%h expected busy=1 done=0 HI=0 LO=0",
                 c, E_busy, md_done, HI, LO);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (md_done !== 1'b1 || E_busy !== 1'b0) begin
      failures++; $display("FAIL mult_c6_done: got done=%b busy=%b expected done=1 busy=0", md_done, E_busy);
    end
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL mult_result: got HI=%h LO=%h expected HI=ffffffff LO=fffffffa", HI, LO);
    end
    step();
    @(negedge clk);
    checks++;
    if (md_done !== 1'b0) begin
      failures++; $display("FAIL mult_done_pulse: got %b expected 0", md_done);
    end
    step();
  endtask

  task automatic test_divu_stall();
    D_uses_md = 1'b1;
    E_start = 1'b1; E_md_op = 3'd4; E_A = 32'd100; E_B = 32'd7;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (md_stall !== 1'b1) begin
        failures++; $display("FAIL divu_stall_c%0d: got %b expected 1", c, md_stall);
      end
      step();
      E_start = 1'b0; E_md_op = 3'd0;
    end
    @(negedge clk);
    checks++;
    if (md_stall !== 1'b0 || md_done !== 1'b1) begin
      failures++; $display("FAIL divu_c11: got stall=%b done=%b expected stall=0 done=1", md_stall, md_done);
    end
    checks++;
    if (HI !== 32'd2 || LO !== 32'd14) begin
      failures++; $display("FAIL divu_result: got HI=%h LO=%h expected HI=2 LO=e", HI, LO);
    end
    D_uses_md = 1'b0;
    step();
  endtask

  task automatic test_div_signed();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 10);
    @(negedge clk);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD || md_done !== 1'b1) begin
      failures++;
      $display("FAIL div_neg7_by_2: got HI=%h LO=%h done=%b expected HI=ffffffff LO=fffffffd done=1", HI, LO, md_done);
    end
    step();
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    @(negedge clk);
    checks++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
      failures++; $display("FAIL div_overflow: got HI=%h LO=%h expected HI=0 LO=80000000", HI, LO);
    end
    step();
  endtask

  task automatic test_mthi_mtlo_divzero();
    E_start = 1'b1; E_md_op = 3'd5; E_A = 32'h1234;
    step();
    E_md_op = 3'd6; E_A = 32'h5678;
    @(negedge clk);
    checks++;
    if (HI !== 32'h1234 || E_busy !== 1'b0) begin
      failures++; $display("FAIL mthi: got HI=%h busy=%b expected HI=1234 busy=0", HI, E_busy);
    end
    step();
    E_start = 1'b0; E_md_op = 3'd0;
    @(negedge clk);
    checks++;
    if (LO !== 32'h5678 || E_busy !== 1'b0 || md_done !== 1'b0) begin
      failures++; $display("FAIL mtlo: got LO=%h busy=%b done=%b expected LO=5678 busy=0 done=0", LO, E_busy, md_done);
    end
    E_start = 1'b1; E_md_op = 3'd3; E_A = 32'd5; E_B = 32'd0;
    step();
    E_start = 1'b0; E_md_op = 3'd0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (E_busy !== 1'b1) begin
        failures++; $display("FAIL div0_busy_c%0d: got %b expected 1", c, E_busy);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (E_busy !== 1'b0 || HI !== 32'h1234 || LO !== 32'h5678) begin
      failures++; $display("FAIL div0_unchanged: got busy=%b HI=%h LO=%h expected busy=0 HI=1234 LO=5678", E_busy, HI, LO);
    end
    step();
  endtask

  task automatic test_reset_abort();
    D_uses_md = 1'b1;
    issue(3'd1, 32'd3, 32'd4, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (E_busy !== 1'b0 || md_stall !== 1'b0 || md_done !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
        failures++;
        $display("FAIL abort_c%0d: got busy=%b stall=%b done=%b HI=%h LO=%h expected all 0",
                 c, E_busy, md_stall, md_done, HI, LO);
      end
      step();
    end
    D_uses_md = 1'b0;
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5);
    @(negedge clk);
    checks++;
    if (HI !== 32'd1 || LO !== 32'hFFFF_FFFE || md_done !== 1'b1) begin
      failures++; $display("FAIL multu_after_abort: got HI=%h LO=%h done=%b expected HI=1 LO=fffffffe done=1", HI, LO, md_done);
    end
    step();
  endtask

  task automatic test_no_stall_ignore();
    D_uses_md = 1'b0;
    E_start = 1'b1; E_md_op = 3'd3; E_A = 32'hFFFF_FF9C; E_B = 32'd7;
    step();
    E_start = 1'b0; E_md_op = 3'd0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        E_start = 1'b1; E_md_op = 3'd1; E_A = 32'd2; E_B = 32'd2;
      end
      @(negedge clk);
      checks++;
      if (md_stall !== 1'b0 || E_busy !== 1'b1) begin
        failures++; $display("FAIL nostall_c%0d: got stall=%b busy=%b expected stall=0 busy=1", c, md_stall, E_busy);
      end
      step();
      E_start = 1'b0; E_md_op = 3'd0;
    end
    @(negedge clk);
    checks++;
    if (md_done !== 1'b1 || HI !== 32'hFFFF_FFFE || LO !== 32'hFFFF_FFF2) begin
      failures++; $display("FAIL ignored_start_result: got done=%b HI=%h LO=%h expected done=1 HI=fffffffe LO=fffffff2", md_done, HI, LO);
    end
    step();
    @(negedge clk);
    checks++;
    if (E_busy !== 1'b0 || md_done !== 1'b0) begin
      failures++; $display("FAIL ignored_start_idle: got busy=%b done=%b expected 0 0", E_busy, md_done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_stall();
    test_div_signed();
    test_mthi_mtlo_divzero();
    test_reset_abort();
    test_no_stall_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
